// File: rtl/tlul_reg_adapter.sv
// TL-UL (32-bit) type package and a single-outstanding TL-UL device adapter
// that turns one accepted a-channel request into a register-file strobe and a d-channel response.
package tluh_32_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// Handshakes: a beat transfers on a clock edge where valid & ready are both high; a_ready depends
// on state only, and d_valid/d-fields stay frozen until d_ready is seen high.
module tlul_reg_adapter
  import tluh_32_pkg::*;
#(
  parameter int RegAw     = 8,
  parameter int RdLatency = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  tl_h2d_t          tl_i,
  output tl_d2h_t          tl_o,
  input  logic             tl_err_i,
  output logic             re_o,
  output logic             we_o,
  output logic [RegAw-1:0] addr_o,
  output logic [31:0]      wdata_o,
  output logic [3:0]       be_o,
  input  logic [31:0]      rdata_i,
  input  logic             error_i,
  output logic [1:0]       o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  localparam logic [2:0] LatM1 = (RdLatency > 0) ? 3'(RdLatency - 1) : 3'd0;

  state_e            r_state;
  logic              r_is_get;
  logic [1:0]        r_size;
  logic [7:0]        r_source;
  logic [2:0]        r_cnt;
  logic              r_re;
  logic              r_we;
  logic [RegAw-1:0]  r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_d_valid;
  logic [2:0]        r_d_opcode;
  logic [1:0]        r_d_size;
  logic [7:0]        r_d_source;
  logic [31:0]       r_d_data;
  logic              r_d_error;

  logic              w_accept;
  logic              w_a_get;
  logic              w_a_put;
  logic              w_req_err;
  logic [RegAw-1:0]  w_a_addr;
  logic              w_unused;

  assign w_accept  = tl_i.a_valid & (r_state == IDLE);
  assign w_a_get   = (tl_i.a_opcode == Get);
  assign w_a_put   = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
  assign w_req_err = tl_err_i | (|tl_i.a_address[31:RegAw]);
  assign w_a_addr  = {tl_i.a_address[RegAw-1:2], 2'b00};
  assign w_unused  = ^{tl_i.a_param, tl_i.a_address[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_is_get   <= 1'b0;
      r_size     <= '0;
      r_source   <= '0;
      r_cnt      <= '0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      r_re <= 1'b0;
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_get <= w_a_get;
            r_size   <= tl_i.a_size;
            r_source <= tl_i.a_source;
            r_addr   <= w_a_addr;
            r_wdata  <= tl_i.a_data;
            r_be     <= tl_i.a_mask;
            if (w_req_err) begin
              // Rejected requests skip the register file and answer on the next cycle.
              r_state    <= RESP;
              r_d_valid  <= 1'b1;
              r_d_opcode <= w_a_get ? AccessAckData : AccessAck;
              r_d_size   <= tl_i.a_size;
              r_d_source <= tl_i.a_source;
              r_d_data   <= w_a_get ? 32'hFFFF_FFFF : 32'h0;
              r_d_error  <= 1'b1;
            end else begin
              r_state <= ACCESS;
              r_re    <= w_a_get;
              r_we    <= w_a_put;
            end
          end
        end
        ACCESS: begin
          if (r_is_get && (RdLatency > 0)) begin
            r_state <= WAIT;
            r_cnt   <= LatM1;
          end else begin
            r_state    <= RESP;
            r_d_valid  <= 1'b1;
            r_d_opcode <= r_is_get ? AccessAckData : AccessAck;
            r_d_size   <= r_size;
            r_d_source <= r_source;
            r_d_data   <= r_is_get ? rdata_i : 32'h0;
            r_d_error  <= error_i;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state    <= RESP;
            r_d_valid  <= 1'b1;
            r_d_opcode <= AccessAckData;
            r_d_size   <= r_size;
            r_d_source <= r_source;
            r_d_data   <= rdata_i;
            r_d_error  <= error_i;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (tl_i.d_ready) begin
            r_state   <= IDLE;
            r_d_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (r_state == IDLE);
    tl_o.d_valid  = r_d_valid;
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
  end

  assign re_o        = r_re;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign be_o        = r_be;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tlul_reg_adapter.sv
// Directed bench for tlul_reg_adapter: a transaction-timeline model predicts every output each cycle.
module tb_tlul_reg_adapter;
  import tluh_32_pkg::*;

  localparam int L  = 2;
  localparam int AW = 8;
  localparam int W  = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  tl_h2d_t       tl_i;
  tl_d2h_t       tl_o;
  logic          tl_err;
  logic          re, we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   rdata;
  logic          err_in;
  logic [1:0]    dbg_state;

  tlul_reg_adapter #(.RegAw(AW), .RdLatency(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o), .tl_err_i(tl_err),
    .re_o(re), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
    .rdata_i(rdata), .error_i(err_in), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cyc = -1;
  logic [31:0] rd_val = 32'h0;
  int err_cyc = -1;
  int we_count = 0;
  int re_count = 0;

  // Model: one transaction in flight, described by the cycles at which things must happen.
  bit            m_busy;
  bit            m_get, m_put, m_err;
  int            m_strobe_c, m_sample_c, m_resp_c;
  logic [1:0]    m_size;
  logic [7:0]    m_src;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_be;
  logic [W-1:0]  exp_q[$];

  function automatic logic [W-1:0] rsp_word(input logic [2:0] op, input logic [1:0] sz,
                                            input logic [7:0] src, input logic [31:0] d,
                                            input logic e);
    return {op, sz, src, d, e, 3'b000, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_get = 0; m_put = 0; m_err = 0;
    m_strobe_c = -1; m_sample_c = -1; m_resp_c = -1;
    m_size = '0; m_src = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    bit exp_dv;
    logic [W-1:0] act_w;
    exp_dv = m_busy && (cyc >= m_resp_c);
    chk("a_ready", 64'(tl_o.a_ready), 64'(!m_busy));
    chk("re_o", 64'(re), 64'(m_busy && !m_err && m_get && cyc == m_strobe_c));
    chk("we_o", 64'(we), 64'(m_busy && !m_err && m_put && cyc == m_strobe_c));
    chk("d_valid", 64'(tl_o.d_valid), 64'(exp_dv));
    chk("addr_o", 64'(addr), 64'(m_addr));
    chk("wdata_o", 64'(wdata), 64'(m_wdata));
    chk("be_o", 64'(be), 64'(m_be));
    if (exp_dv) begin
      act_w = {tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error,
               tl_o.d_param, tl_o.d_sink};
      if (exp_q.size() == 0) chk("rsp_missing", 64'(act_w), 64'hDEAD);
      else                   chk("d_fields", 64'(act_w), 64'(exp_q[0]));
    end
  endtask

  task automatic model_update();
    if (m_busy && !m_err && cyc == m_sample_c)
      exp_q.push_back(rsp_word(m_get ? AccessAckData : AccessAck, m_size, m_src,
                               m_get ? rdata : 32'h0, err_in));
    if (m_busy && cyc >= m_resp_c) begin
      if (tl_i.d_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 0;
      end
    end else if (!m_busy && tl_i.a_valid) begin
      m_busy     = 1;
      m_get      = (tl_i.a_opcode == Get);
      m_put      = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
      m_err      = tl_err || (tl_i.a_address >= 32'(1 << AW));
      m_size     = tl_i.a_size;
      m_src      = tl_i.a_source;
      m_addr     = tl_i.a_address[AW-1:0] & ~AW'(3);
      m_wdata    = tl_i.a_data;
      m_be       = tl_i.a_mask;
      m_strobe_c = cyc + 1;
      m_sample_c = m_get ? cyc + 1 + L : cyc + 1;
      m_resp_c   = m_err ? cyc + 1 : m_sample_c + 1;
      if (m_err)
        exp_q.push_back(rsp_word(m_get ? AccessAckData : AccessAck, m_size, m_src,
                                 m_get ? 32'hFFFF_FFFF : 32'h0, 1'b1));
    end
  endtask

  task automatic tick();
    rdata  = (cyc == rd_cyc) ? rd_val : (32'hBAD0_0000 ^ 32'(cyc));
    err_in = (cyc == err_cyc);
    check_outputs();
    model_update();
    if (we) we_count++;
    if (re) re_count++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [7:0] src, input logic [1:0] sz,
                      input logic terr);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_param = 3'd0; tl_i.a_size = sz;
    tl_i.a_source = src; tl_i.a_address = a; tl_i.a_data = d; tl_i.a_mask = m;
    tl_err = terr;
    tick();
    tl_i.a_valid = 1'b0;
    tl_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int wc;
    int rc;
    tl_d2h_t rst_exp;
    tl_i = '0; tl_i.d_ready = 1'b1; tl_err = 1'b0; rdata = '0; err_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_exp = '0; rst_exp.a_ready = 1'b1;
    chk("rst_tl_o", 64'(tl_o), 64'(rst_exp));
    chk("rst_strobes", 64'({re, we, addr, wdata, be}), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Write, no error.
    n = cyc;
    send(PutFullData, 32'h04, 32'hDEAD_BEEF, 4'hF, 8'd3, 2'd2, 1'b0);
    chk("wr_we", 64'({we, re}), 64'b10);
    chk("wr_addr", 64'(addr), 64'h04);
    chk("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);
    chk("wr_be", 64'(be), 64'hF);
    tick();
    chk("wr_rsp", 64'({tl_o.d_valid, tl_o.d_opcode, tl_o.d_source, tl_o.d_error}),
        64'({1'b1, 3'd0, 8'd3, 1'b0}));
    chk("wr_lat", 64'(cyc - n), 64'd2);
    idle(2);

    // Read with latency 2: data presented only in N+3.
    n = cyc; rd_cyc = n + 3; rd_val = 32'h1234_5678;
    send(Get, 32'h10, 32'h0, 4'hF, 8'd5, 2'd2, 1'b0);
    chk("rd_re", 64'({re, we}), 64'b10);
    idle(3);
    chk("rd_rsp", 64'({tl_o.d_valid, tl_o.d_opcode, tl_o.d_data, tl_o.d_error}),
        64'({1'b1, 3'd1, 32'h1234_5678, 1'b0}));
    idle(2);

    // Integrity-checker error on a Get.
    wc = we_count; rc = re_count;
    send(Get, 32'h20, 32'h0, 4'hF, 8'd7, 2'd2, 1'b1);
    chk("terr_rsp", 64'({tl_o.d_valid, tl_o.d_opcode, tl_o.d_data, tl_o.d_error}),
        64'({1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1}));
    idle(2);

    // Out-of-range PutPartialData.
    send(PutPartialData, 32'h100, 32'h5555_AAAA, 4'h3, 8'd9, 2'd1, 1'b0);
    chk("oor_rsp", 64'({tl_o.d_valid, tl_o.d_opcode, tl_o.d_error}), 64'({1'b1, 3'd0, 1'b1}));
    idle(2);
    chk("err_no_strobe", 64'({we_count - wc, re_count - rc}), 64'h0);

    // Read returning error_i keeps the sampled data; write returning error_i.
    n = cyc; rd_cyc = n + 3; rd_val = 32'hCAFE_F00D; err_cyc = n + 3;
    send(Get, 32'h08, 32'h0, 4'hF, 8'd11, 2'd2, 1'b0);
    idle(3);
    chk("rderr_rsp", 64'({tl_o.d_data, tl_o.d_error}), 64'({32'hCAFE_F00D, 1'b1}));
    idle(1);
    n = cyc; err_cyc = n + 1;
    send(PutFullData, 32'h2C, 32'h0BAD_C0DE, 4'h6, 8'd12, 2'd2, 1'b0);
    idle(1);
    chk("wrerr_rsp", 64'({tl_o.d_valid, tl_o.d_error}), 64'b11);
    idle(1);

    // Backpressure with new requests knocking on a_valid.
    tl_i.d_ready = 1'b0;
    send(PutFullData, 32'h0C, 32'h0102_0304, 4'hF, 8'd4, 2'd2, 1'b0);
    idle(1);
    wc = we_count; rc = re_count;
    for (int k = 0; k < 5; k++) begin
      tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h14;
      tl_i.a_source = 8'(20 + k); tl_err = 1'(k % 2);
      tick();
    end
    chk("bp_no_strobe", 64'({we_count - wc, re_count - rc}), 64'h0);
    tl_i.a_valid = 1'b0; tl_err = 1'b0; tl_i.d_ready = 1'b1;
    tick();
    chk("bp_a_ready", 64'(tl_o.a_ready), 64'h1);
    idle(1);

    // Back-to-back writes with a_valid held high: 3 cycles per transaction.
    wc = we_count;
    for (int i = 0; i < 9; i++) begin
      tl_i.a_valid = 1'b1; tl_i.a_opcode = PutFullData; tl_i.a_address = 32'(4 * i);
      tl_i.a_data = $urandom_range(32'hFFFF, 0); tl_i.a_mask = 4'hF; tl_i.a_source = 8'(i);
      tick();
    end
    tl_i.a_valid = 1'b0;
    idle(2);
    chk("b2b_writes", 64'(we_count - wc), 64'd3);

    // Asynchronous reset while waiting for read data.
    send(Get, 32'h18, 32'h0, 4'hF, 8'd30, 2'd2, 1'b0);
    idle(1);
    chk("wait_state", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_out", 64'({tl_o.d_valid, tl_o.a_ready, re, we, addr}), 64'({4'b0100, 8'h0}));
    model_reset();
    idle(2);
    rst_n = 1'b1;
    rc = re_count;
    idle(5);
    chk("post_rst_no_re", 64'(re_count - rc), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
